// File: rtl/r200_pipecont.sv
// -----------------------------------------------------------------------------
// r200_pipecont
//
// Central sequencing controller for the r200 five-stage pipeline
// (IF, ID, EX, MEM, WB). It produces the PC controls, the load enables and
// bubble (flush) controls for the four pipeline registers, and the 3-bit
// operand bypass selects for the rs1/rs2 mux8w32 muxes. It also runs the
// boot sequence and freezes the pipeline while data memory inserts wait
// states.
//
// Optional feature macro: R200_FWD_EN
//   defined   : operand bypassing enabled, selects take 0/2/4/6/7
//   undefined : selects are constant 0, every RAW match stalls
//
// Parameters
//   BOOT_CYCLES  (1..15) cycles pc_rst is held after reset release
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs1/rs2  ID stage source registers and use flags
//   ex_/mem_/wb_ rd, regwr, wbsel   producer info per stage
//                                   (wbsel 0 = ALU, 1 = dmem, 2 = pc+4)
//   ex_willbr, ex_willjmp           taken branch / jump resolved in EX
//   mem_memop, dmem_ack             memory access in MEM and its completion
//   stall_clr                       synchronous clear of stall_cnt
//   pc_rst, pc_en, pc_sel           PC control (sel 0 = pc+4, 1 = branch,
//                                   2 = jump target)
//   *_en, *_flush                   pipeline register load / bubble controls
//   rs1val_cont, rs2val_cont        bypass selects (0 regfile, 2 EX ALU,
//                                   4 MEM ALU, 6 WB ALU, 7 WB dmem)
//   dmem_req                        memory access pending
//   stall_cnt                       saturating stalled-cycle counter
//   dbg_state                       current FSM state (debug observation)
//
// Memory handshake: a memory op sitting in MEM completes in the cycle where
// dmem_ack is high. While mem_memop is high and dmem_ack is low, dmem_req is
// high and the whole pipeline (PC and all four registers) holds. The cycle
// that carries dmem_ack is evaluated as a normal run cycle.
// -----------------------------------------------------------------------------
module r200_pipecont #(
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_regwr,
  input  logic        mem_regwr,
  input  logic        wb_regwr,
  input  logic [1:0]  ex_wbsel,
  input  logic [1:0]  mem_wbsel,
  input  logic [1:0]  wb_wbsel,
  input  logic        ex_willbr,
  input  logic        ex_willjmp,
  input  logic        mem_memop,
  input  logic        dmem_ack,
  input  logic        stall_clr,
  output logic        pc_rst,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic [2:0]  rs1val_cont,
  output logic [2:0]  rs2val_cont,
  output logic        dmem_req,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;

  localparam logic [2:0] SEL_RF     = 3'd0;
  localparam logic [2:0] SEL_EX_ALU = 3'd2;
  localparam logic [2:0] SEL_MEM_ALU = 3'd4;
  localparam logic [2:0] SEL_WB_ALU = 3'd6;
  localparam logic [2:0] SEL_WB_MEM = 3'd7;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Hazard detection per source operand
  // ---------------------------------------------------------------------------
  logic       s1_ex_hit, s1_mem_hit, s1_wb_hit;
  logic       s2_ex_hit, s2_mem_hit, s2_wb_hit;
  logic       s1_stall, s2_stall;
  logic [2:0] s1_sel, s2_sel;
  logic       raw_stall;

  // x0 is hard-wired zero, so a producer writing x0 never matches.
  assign s1_ex_hit  = id_uses_rs1 && ex_regwr  && (ex_rd  != 5'd0) && (ex_rd  == id_rs1);
  assign s1_mem_hit = id_uses_rs1 && mem_regwr && (mem_rd != 5'd0) && (mem_rd == id_rs1);
  assign s1_wb_hit  = id_uses_rs1 && wb_regwr  && (wb_rd  != 5'd0) && (wb_rd  == id_rs1);
  assign s2_ex_hit  = id_uses_rs2 && ex_regwr  && (ex_rd  != 5'd0) && (ex_rd  == id_rs2);
  assign s2_mem_hit = id_uses_rs2 && mem_regwr && (mem_rd != 5'd0) && (mem_rd == id_rs2);
  assign s2_wb_hit  = id_uses_rs2 && wb_regwr  && (wb_rd  != 5'd0) && (wb_rd  == id_rs2);

`ifdef R200_FWD_EN
  // Only the youngest matching producer matters: it holds the newest value.
  // If that producer cannot be bypassed the consumer stalls, even when an
  // older matching stage could be.
  function automatic logic [3:0] resolve(
    input logic       ex_hit,
    input logic       mem_hit,
    input logic       wb_hit,
    input logic [1:0] exs,
    input logic [1:0] mems,
    input logic [1:0] wbs
  );
    logic [3:0] r;  // {stall, sel[2:0]}
    r = {1'b0, SEL_RF};
    if (ex_hit) begin
      r = (exs == WB_ALU) ? {1'b0, SEL_EX_ALU} : {1'b1, SEL_RF};
    end else if (mem_hit) begin
      r = (mems == WB_ALU) ? {1'b0, SEL_MEM_ALU} : {1'b1, SEL_RF};
    end else if (wb_hit) begin
      if (wbs == WB_ALU)       r = {1'b0, SEL_WB_ALU};
      else if (wbs == WB_DMEM) r = {1'b0, SEL_WB_MEM};
      else                     r = {1'b1, SEL_RF};
    end
    return r;
  endfunction

  assign {s1_stall, s1_sel} = resolve(s1_ex_hit, s1_mem_hit, s1_wb_hit,
                                      ex_wbsel, mem_wbsel, wb_wbsel);
  assign {s2_stall, s2_sel} = resolve(s2_ex_hit, s2_mem_hit, s2_wb_hit,
                                      ex_wbsel, mem_wbsel, wb_wbsel);
`else
  // No bypass network: any in-flight producer of a used source stalls ID.
  logic unused_wbsel;
  assign unused_wbsel = ^{ex_wbsel, mem_wbsel, wb_wbsel};

  assign s1_stall = s1_ex_hit || s1_mem_hit || s1_wb_hit;
  assign s2_stall = s2_ex_hit || s2_mem_hit || s2_wb_hit;
  assign s1_sel   = SEL_RF;
  assign s2_sel   = SEL_RF;
`endif

  assign raw_stall = s1_stall || s2_stall;

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  logic in_boot;
  logic freeze;
  logic eval_run;

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    in_boot      = 1'b0;
    freeze       = 1'b0;
    eval_run     = 1'b0;

    pc_rst       = 1'b0;
    pc_en        = 1'b1;
    pc_sel       = 2'd0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    rs1val_cont  = s1_sel;
    rs2val_cont  = s2_sel;
    dmem_req     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        in_boot = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (mem_memop && !dmem_ack) begin
          freeze  = 1'b1;
          state_d = ST_MEMWAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (!dmem_ack) begin
          freeze = 1'b1;
        end else begin
          // The ack cycle behaves as a run cycle, so a redirect held in EX
          // during the wait is applied here.
          eval_run = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        in_boot    = 1'b1;
        state_d    = ST_BOOT;
        boot_cnt_d = 4'd0;
      end
    endcase

    if (in_boot) begin
      // PC held in reset while every pipeline register loads a bubble.
      pc_rst       = 1'b1;
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      rs1val_cont  = SEL_RF;
      rs2val_cont  = SEL_RF;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      dmem_req  = 1'b1;
    end else if (eval_run) begin
      if (ex_willjmp || ex_willbr) begin
        // Redirect overrides a RAW stall: the stalled instruction in ID is
        // on the wrong path and is flushed anyway.
        pc_sel      = ex_willjmp ? 2'd2 : 2'd1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (raw_stall) begin
        // Hold PC and IF/ID, inject a bubble into EX, let EX..WB drain.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Redirect cycles always have pc_en=1, so !pc_en outside boot is exactly a
  // non-redirect stalled cycle (RAW stall or memory freeze).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = 16'd0;
    end else if (!in_boot && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_r200_pipecont.sv
// -----------------------------------------------------------------------------
// tb_r200_pipecont
//
// Directed bench for r200_pipecont. Each cycle the stimulus is driven just
// after the rising edge, the expected control word and stall count are pushed
// onto exp_q, and the DUT outputs are sampled on the falling edge and compared
// against the popped entry. Expected values follow the build: with
// R200_FWD_EN defined they reflect bypassing, otherwise every RAW match stalls.
// -----------------------------------------------------------------------------
module tb_r200_pipecont;

  localparam int W = 35;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_uses_rs1, id_uses_rs2;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwr, mem_regwr, wb_regwr;
  logic [1:0]  ex_wbsel, mem_wbsel, wb_wbsel;
  logic        ex_willbr, ex_willjmp;
  logic        mem_memop, dmem_ack, stall_clr;
  logic        pc_rst, pc_en;
  logic [1:0]  pc_sel;
  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [2:0]  rs1val_cont, rs2val_cont;
  logic        dmem_req;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  r200_pipecont #(.BOOT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
    .ex_wbsel(ex_wbsel), .mem_wbsel(mem_wbsel), .wb_wbsel(wb_wbsel),
    .ex_willbr(ex_willbr), .ex_willjmp(ex_willjmp),
    .mem_memop(mem_memop), .dmem_ack(dmem_ack), .stall_clr(stall_clr),
    .pc_rst(pc_rst), .pc_en(pc_en), .pc_sel(pc_sel),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .rs1val_cont(rs1val_cont), .rs2val_cont(rs2val_cont),
    .dmem_req(dmem_req), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [15:0]  exp_cnt = 16'd0;

  logic [W-1:0] obs;
  assign obs = {pc_rst, pc_en, pc_sel,
                if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                rs1val_cont, rs2val_cont, dmem_req, stall_cnt};

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ctl=%h cnt=%h, expected ctl=%h cnt=%h",
               tag, got[W-1:16], got[15:0], exp[W-1:16], exp[15:0]);
    end
  endtask

  // Control word: {pc_rst, pc_en, pc_sel, en[4], flush[4], rs1, rs2, dmem_req}
  function automatic logic [18:0] mk(input logic rst, input logic pen,
                                     input logic [1:0] psel,
                                     input logic [3:0] en, input logic [3:0] fl,
                                     input logic [2:0] s1, input logic [2:0] s2,
                                     input logic req);
    return {rst, pen, psel, en, fl, s1, s2, req};
  endfunction

  function automatic logic [18:0] c_boot();
    return mk(1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 3'd0, 3'd0, 1'b0);
  endfunction
  function automatic logic [18:0] c_norm(input logic [2:0] s1, input logic [2:0] s2);
    return mk(1'b0, 1'b1, 2'd0, 4'hF, 4'h0, s1, s2, 1'b0);
  endfunction
  function automatic logic [18:0] c_stall();
    return mk(1'b0, 1'b0, 2'd0, 4'b0111, 4'b0100, 3'd0, 3'd0, 1'b0);
  endfunction
  function automatic logic [18:0] c_freeze();
    return mk(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 3'd0, 3'd0, 1'b1);
  endfunction
  function automatic logic [18:0] c_redir(input logic [1:0] sel);
    return mk(1'b0, 1'b1, sel, 4'hF, 4'b1100, 3'd0, 3'd0, 1'b0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_regwr = 1'b0; mem_regwr = 1'b0; wb_regwr = 1'b0;
    ex_wbsel = 2'd0; mem_wbsel = 2'd0; wb_wbsel = 2'd0;
    ex_willbr = 1'b0; ex_willjmp = 1'b0;
    mem_memop = 1'b0; dmem_ack = 1'b0; stall_clr = 1'b0;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic [1:0] wbs);
    ex_regwr = 1'b1; ex_rd = rd; ex_wbsel = wbs;
  endtask
  task automatic set_mem(input logic [4:0] rd, input logic [1:0] wbs);
    mem_regwr = 1'b1; mem_rd = rd; mem_wbsel = wbs;
    mem_memop = (wbs == 2'd1); dmem_ack = 1'b1;
  endtask
  task automatic set_wb(input logic [4:0] rd, input logic [1:0] wbs);
    wb_regwr = 1'b1; wb_rd = rd; wb_wbsel = wbs;
  endtask
  task automatic clr_stages();
    ex_regwr = 1'b0; mem_regwr = 1'b0; wb_regwr = 1'b0;
    mem_memop = 1'b0; dmem_ack = 1'b0;
  endtask

  // One cycle: push expectation, compare on the falling edge, then advance.
  // stalled=1 means this cycle must bump the stall counter.
  task automatic expect_cycle(input string tag, input logic [18:0] c,
                              input logic stalled);
    exp_q.push_back({c, exp_cnt});
    @(negedge clk);
    check_eq(tag, obs, exp_q.pop_front());
    @(posedge clk);
    #1;
    if (stalled) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic boot_seq();
    for (int i = 0; i < 4; i++) expect_cycle("boot", c_boot(), 1'b0);
    expect_cycle("boot_done", c_norm(3'd0, 3'd0), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    expect_cycle("reset", c_boot(), 1'b0);
    rst_n = 1'b1;
    boot_seq();

    // ALU producer of x5 walking EX -> MEM -> WB, consumer on rs1.
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    set_ex(5'd5, 2'd0);
`ifdef R200_FWD_EN
    expect_cycle("alu_ex", c_norm(3'd2, 3'd0), 1'b0);
    clr_stages(); set_mem(5'd5, 2'd0);
    expect_cycle("alu_mem", c_norm(3'd4, 3'd0), 1'b0);
    clr_stages(); set_wb(5'd5, 2'd0);
    expect_cycle("alu_wb", c_norm(3'd6, 3'd0), 1'b0);
`else
    expect_cycle("alu_ex", c_stall(), 1'b1);
    clr_stages(); set_mem(5'd5, 2'd0);
    expect_cycle("alu_mem", c_stall(), 1'b1);
    clr_stages(); set_wb(5'd5, 2'd0);
    expect_cycle("alu_wb", c_stall(), 1'b1);
`endif
    clr_stages(); set_ex(5'd0, 2'd0); id_rs1 = 5'd0;
    expect_cycle("rd_x0", c_norm(3'd0, 3'd0), 1'b0);

    // Same register in every stage: EX has priority (MEM one is a load).
    drive_idle();
    id_rs1 = 5'd5; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    set_ex(5'd5, 2'd0); set_mem(5'd5, 2'd1); set_wb(5'd5, 2'd0);
`ifdef R200_FWD_EN
    expect_cycle("prio_ex", c_norm(3'd2, 3'd2), 1'b0);
`else
    expect_cycle("prio_ex", c_stall(), 1'b1);
`endif
    // Matching rd but source unused.
    drive_idle();
    id_rs1 = 5'd5; set_ex(5'd5, 2'd0);
    expect_cycle("unused_src", c_norm(3'd0, 3'd0), 1'b0);

    // MEM ALU on rs1, WB load on rs2.
    drive_idle();
    id_rs1 = 5'd4; id_rs2 = 5'd8; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    set_mem(5'd4, 2'd0); set_wb(5'd8, 2'd1);
`ifdef R200_FWD_EN
    expect_cycle("mem_wbmem", c_norm(3'd4, 3'd7), 1'b0);
`else
    expect_cycle("mem_wbmem", c_stall(), 1'b1);
`endif

    // Load-use on rs2 with a load of x7.
    drive_idle();
    id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    set_ex(5'd7, 2'd1);
    expect_cycle("ld_ex", c_stall(), 1'b1);
    clr_stages(); set_mem(5'd7, 2'd1);
    expect_cycle("ld_mem", c_stall(), 1'b1);
    clr_stages(); set_wb(5'd7, 2'd1);
`ifdef R200_FWD_EN
    expect_cycle("ld_wb", c_norm(3'd0, 3'd7), 1'b0);
`else
    expect_cycle("ld_wb", c_stall(), 1'b1);
`endif
    clr_stages();
    expect_cycle("ld_done", c_norm(3'd0, 3'd0), 1'b0);

    // pc+4 producer in WB is never bypassed.
    drive_idle();
    id_rs1 = 5'd9; id_uses_rs1 = 1'b1; set_wb(5'd9, 2'd2);
    expect_cycle("pc4_wb", c_stall(), 1'b1);

    // Jump in EX coinciding with a RAW stall: redirect wins, nothing counted.
    drive_idle();
    id_rs1 = 5'd1; id_uses_rs1 = 1'b1; set_ex(5'd1, 2'd2); ex_willjmp = 1'b1;
    expect_cycle("jmp_raw", c_redir(2'd2), 1'b0);
    drive_idle(); ex_willbr = 1'b1;
    expect_cycle("br", c_redir(2'd1), 1'b0);
    ex_willjmp = 1'b1;
    expect_cycle("jmp_over_br", c_redir(2'd2), 1'b0);

    // Memory wait of 3 cycles with a taken branch held in EX.
    drive_idle();
    mem_memop = 1'b1; ex_willbr = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("memwait", c_freeze(), 1'b1);
    dmem_ack = 1'b1;
    expect_cycle("memwait_ack", c_redir(2'd1), 1'b0);
    drive_idle();
    expect_cycle("after_ack", c_norm(3'd0, 3'd0), 1'b0);

    // Synchronous clear wins over an increment in the same cycle.
    id_rs1 = 5'd9; id_uses_rs1 = 1'b1; set_wb(5'd9, 2'd2); stall_clr = 1'b1;
    expect_cycle("clr_cycle", c_stall(), 1'b0);
    exp_cnt = 16'd0;
    stall_clr = 1'b0;
    expect_cycle("after_clr", c_stall(), 1'b1);
    drive_idle();
    expect_cycle("cnt_one", c_norm(3'd0, 3'd0), 1'b0);

    // Asynchronous reset while in MEMWAIT.
    mem_memop = 1'b1;
    expect_cycle("pre_rst_run", c_freeze(), 1'b1);
    expect_cycle("pre_rst_wait", c_freeze(), 1'b1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    exp_q.push_back({c_boot(), exp_cnt});
    check_eq("async_rst", obs, exp_q.pop_front());
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_seq();

    check_eq("queue_empty", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/r200_pipecont.md
# r200_pipecont

Central sequencing controller for the r200 five-stage pipeline (IF, ID, EX, MEM, WB). It generates the enable, flush and PC-select controls for the PC and the four pipeline registers, and the 3-bit operand-bypass selects for the rs1/rs2 `mux8w32` muxes. It also runs the boot sequence and freezes the pipeline during data-memory wait states. It replaces the combinational `hazard` and `pccont` stubs with one registered-state controller.

## Interface
- `BOOT_CYCLES`, default 4, range 1..15: cycles `pc_rst` is held after reset release.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source register addresses of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: ID instruction reads that source.
- `ex_rd`, `mem_rd`, `wb_rd` in 5 each: destination register per stage.
- `ex_regwr`, `mem_regwr`, `wb_regwr` in 1 each: stage writes the register file.
- `ex_wbsel`, `mem_wbsel`, `wb_wbsel` in 2 each: 0 = ALU, 1 = dmem, 2 = pc+4.
- `ex_willbr` in 1: branch resolved taken in EX.
- `ex_willjmp` in 1: jal/jalr in EX.
- `mem_memop` in 1: load/store in MEM.
- `dmem_ack` in 1: data memory completes this cycle.
- `stall_clr` in 1: synchronous clear of `stall_cnt`.
- `pc_rst` out 1: PC reset.
- `pc_en` out 1: PC update enable.
- `pc_sel` out 2: 0 = pc+4, 1 = `pc_brtarg`, 2 = `pc_jumptarg`.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: pipeline register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1 each: load a bubble (all control bits 0) instead of the incoming stage.
- `rs1val_cont`, `rs2val_cont` out 3 each: bypass mux select. 0 = regfile, 2 = `ex_alu_res`, 4 = `mem_alu_res`, 6 = `wb_alu_res`, 7 = `wb_dmem_out`.
- `dmem_req` out 1: memory access pending.
- `stall_cnt` out 16: stalled-cycle counter.

## Operation
- States: BOOT, RUN, MEMWAIT, encoded in 2 bits. The boot counter is 4 bits.
- **BOOT**
  - Outputs: `pc_rst`=1, `pc_en`=0, all `*_en`=1, all `*_flush`=1, `pc_sel`=0, selects=0, `dmem_req`=0.
  - The counter increments each cycle. The state goes to RUN after BOOT_CYCLES cycles.
- **RUN**, evaluated in priority order:
  1. **Memory wait.** `mem_memop` && !`dmem_ack` → `dmem_req`=1, all enables 0 (full freeze, no flush), next state MEMWAIT. If `mem_memop` && `dmem_ack` in the same cycle, there is no stall.
  2. **Redirect.** `ex_willjmp` → `pc_sel`=2. Else `ex_willbr` → `pc_sel`=1. On redirect, `pc_en`=1 and `if_id_flush`=`id_ex_flush`=1.
  3. **RAW stall.** Conditions:
     - A used source equals a producing stage's rd, where rd≠0 and regwr=1.
     - That producer cannot be bypassed.
     - Action: `pc_en`=`if_id_en`=0 and `id_ex_flush`=1 (bubble into EX). Later stages advance.
  4. **Otherwise:** all enables 1, no flush, `pc_sel`=0.
- **Bypassable producers.** With forwarding compiled in, the bypassable producers are:
  - EX, MEM or WB with wbsel=ALU (sel 2/4/6 respectively).
  - WB with wbsel=dmem (sel 7).
  - Loads in EX or MEM and pc+4 producers in any stage stall instead.
- **Bypass priority:** EX > MEM > WB. An rd of x0 never matches. The select is 0 when the source is unused or has no match.
- **MEMWAIT**
  - Outputs: `dmem_req`=1, all enables 0, no flush, `stall_cnt` counting.
  - On `dmem_ack`, the ack cycle evaluates as RUN (rules 2–4 apply) and the state goes to RUN.
- **`stall_cnt`**
  - Increments in every RUN/MEMWAIT cycle with `pc_en`=0 and no redirect.
  - Saturates at 0xFFFF.
  - `stall_clr` has priority over increment.
- **Asynchronous reset** mid-operation: immediate return to BOOT, counter 0, `stall_cnt` 0. Outputs take BOOT values within the same cycle.

## Timing
- The bypass selects, flushes and enables are combinational from state plus inputs; the same-cycle path is from the ID/EX/MEM/WB fields.
- Reset values: `pc_rst`=1, `pc_en`=0, all enables 1, all flushes 1, `pc_sel`=0, selects 0, `dmem_req`=0, `stall_cnt`=0.
- Load-use penalty is 2 cycles; the consumer takes sel 7 on the third cycle.
- The taken branch/jump penalty is 2 bubbles.
- A MEMWAIT lasting N cycles adds N stall cycles. A redirect pending in EX during MEMWAIT is applied on the ack cycle.
- A redirect coinciding with a RAW stall: the redirect wins and no stall is counted.

## Configuration
- **`R200_FWD_EN` defined:** bypassing as above, and selects take values 0/2/4/6/7.
- **`R200_FWD_EN` undefined:**
  - Selects are constant 0.
  - Every RAW match against EX, MEM or WB stalls. The register file does not bypass.
  - Load-use penalty becomes 3 cycles, and ALU-use becomes 3/2/1 cycles.

## Test plan
- **Boot:** release `rst_n` with BOOT_CYCLES=4 → `pc_rst`=1 for 4 cycles, then `pc_en`=1 and flushes 0 on cycle 5.
- **ALU forwarding:** ex_rd=5 ALU, `id_rs1`=5 → `rs1val_cont`=2. Next cycle (MEM) → 4. Then (WB) → 6. With rd=0 → 0.
- **Load-use:** load x7 in EX, `id_rs2`=x7 → 2 cycles with `pc_en`=0 and `id_ex_flush`=1, then `rs2val_cont`=7, and `stall_cnt` increments by 2.
- **Memory wait:** `mem_memop`=1 with `dmem_ack` low for 3 cycles while `ex_willbr`=1 → full freeze for 3 cycles, `dmem_req`=1. On the ack cycle, `pc_sel`=1 and `if_id_flush`=`id_ex_flush`=1.
- **Mid-operation reset:** assert `rst_n`=0 during MEMWAIT → same-cycle BOOT outputs, `stall_cnt`=0, `dmem_req`=0.
- **Forwarding disabled:** build without `R200_FWD_EN`, with an ALU producer of x3 in EX and `id_rs1`=3 → 3 stall cycles, and `rs1val_cont`=0 throughout.
